// File: rtl/hvac_sequencer.sv
// Thermostat run controller: hysteresis-based HEAT/COOL demand with a minimum
// run time and a post-run compressor lockout, advancing only on tick strobes.
module hvac_sequencer #(
  parameter int unsigned HYST    = 2,
  parameter int unsigned MIN_RUN = 8,
  parameter int unsigned MIN_OFF = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       temp_set,
  input  logic [6:0] desired_temp,
  input  logic [6:0] temp_in,
  output logic       heat_on,
  output logic       cool_on,
  output logic [2:0] rgb_out,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEAT    = 2'b01,
    COOL    = 2'b10,
    LOCKOUT = 2'b11
  } state_e;

  localparam logic [7:0] HYST_W   = 8'(HYST);
  localparam logic [7:0] RUN_LOAD = 8'(MIN_RUN - 1);
  localparam logic [7:0] OFF_LOAD = 8'(MIN_OFF - 1);

  logic       tempSet_q;
  logic [6:0] desired_q;
  logic [6:0] tempIn_q;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       heatOn_q, coolOn_q;
  logic [2:0] rgb_q;

  logic [7:0] tempWide;
  logic [7:0] desiredWide;
  logic       needHeat;
  logic       needCool;
  logic       heatSatisfied;
  logic       coolSatisfied;

  function automatic logic [2:0] rgbFor(input state_e s);
    logic [2:0] code;
    case (s)
      HEAT:    code = 3'b100;
      COOL:    code = 3'b001;
      LOCKOUT: code = 3'b110;
      default: code = 3'b010;
    endcase
    return code;
  endfunction

  // Operands are widened to 8 bits so adding the band never wraps.
  assign tempWide      = {1'b0, tempIn_q};
  assign desiredWide   = {1'b0, desired_q};
  assign needHeat      = tempSet_q && ((tempWide + HYST_W) < desiredWide);
  assign needCool      = tempSet_q && (tempWide > (desiredWide + HYST_W));
  assign heatSatisfied = !tempSet_q || (tempIn_q >= desired_q);
  assign coolSatisfied = !tempSet_q || (tempIn_q <= desired_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (needHeat) begin
            state_d = HEAT;
            cnt_d   = RUN_LOAD;
          end else if (needCool) begin
            state_d = COOL;
            cnt_d   = RUN_LOAD;
          end
        end
        HEAT: begin
          if (cnt_q == 8'd0 && heatSatisfied) begin
            state_d = LOCKOUT;
            cnt_d   = OFF_LOAD;
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        COOL: begin
          if (cnt_q == 8'd0 && coolSatisfied) begin
            state_d = LOCKOUT;
            cnt_d   = OFF_LOAD;
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        LOCKOUT: begin
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tempSet_q <= 1'b0;
      desired_q <= 7'd0;
      tempIn_q  <= 7'd0;
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      heatOn_q  <= 1'b0;
      coolOn_q  <= 1'b0;
      rgb_q     <= 3'b010;
    end else begin
      tempSet_q <= temp_set;
      desired_q <= desired_temp;
      tempIn_q  <= temp_in;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      heatOn_q  <= (state_d == HEAT);
      coolOn_q  <= (state_d == COOL);
      rgb_q     <= rgbFor(state_d);
    end
  end

  assign heat_on   = heatOn_q;
  assign cool_on   = coolOn_q;
  assign rgb_out   = rgb_q;
  assign state_out = state_q;

endmodule

// File: doc/hvac_sequencer.md
# hvac_sequencer

Thermostat run controller that decides when heating or cooling equipment is energised. It compares the measured temperature against the user setpoint with a hysteresis band, and enforces a minimum run time and a minimum off-time (compressor lockout) between runs. It sits between the temperature/setpoint registers and the equipment drive pins. It also produces the 3-bit status LED code for the RGB indicator. All decisions advance only on a periodic `tick` strobe, so timing constants are expressed in ticks, not clocks.

## Interface
- `HYST`, default 2: hysteresis band in degrees; 0..15.
- `MIN_RUN`, default 8: minimum HEAT/COOL duration in ticks; 1..255.
- `MIN_OFF`, default 4: lockout duration in ticks after any run; 1..255.

- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `tick`  input  1  one-cycle decision strobe; all other cycles hold state and counter.
- `temp_set`  input  1  thermostat enabled; 0 means no new run may start.
- `desired_temp`  input  7  setpoint, unsigned degrees.
- `temp_in`  input  7  measured temperature, unsigned degrees.
- `heat_on`  output  1  heater drive; high exactly while state is HEAT.
- `cool_on`  output  1  cooler drive; high exactly while state is COOL.
- `rgb_out`  output  3  status code: HEAT 100, COOL 001, IDLE 010, LOCKOUT 110.
- `state_out`  output  2  state encoding: IDLE 00, HEAT 01, COOL 10, LOCKOUT 11.

## Operation
- Input registration:
  - `temp_set`, `desired_temp` and `temp_in` are registered every clk.
  - Decisions use only the registered copies.
- Width rule: all comparisons are made in 8-bit unsigned arithmetic on zero-extended operands, so no wrap-around occurs.
  - need_heat = temp_set_r && (temp_in_r + HYST < desired_r).
  - need_cool = temp_set_r && (temp_in_r > desired_r + HYST).
  - need_heat and need_cool are mutually exclusive by construction.
- Run counter `cnt` is 8 bits:
  - On a tick where `cnt` ≠ 0 and no transition occurs, it decrements.
  - It is loaded on state entry as listed below.
  - It never underflows.
- Transitions are evaluated only on `tick` cycles:
  - IDLE: need_heat → HEAT with cnt = MIN_RUN−1. Otherwise need_cool → COOL with cnt = MIN_RUN−1. Otherwise stay.
  - HEAT: if cnt = 0 and (!temp_set_r or temp_in_r ≥ desired_r) → LOCKOUT with cnt = MIN_OFF−1. Otherwise stay and decrement.
  - COOL: if cnt = 0 and (!temp_set_r or temp_in_r ≤ desired_r) → LOCKOUT with cnt = MIN_OFF−1. Otherwise stay and decrement.
  - LOCKOUT: if cnt = 0 → IDLE. Otherwise decrement. Requests are ignored during lockout.
- No direct HEAT↔COOL transition exists; every run passes through LOCKOUT.
- Dropping `temp_set` mid-run does not cut the minimum run short. The run ends on the first tick with cnt = 0.
- Setpoint changes mid-run are honoured on the next tick, subject to the cnt = 0 rule.
- All outputs are decoded from the state register; they are glitch-free and hold between ticks.

## Timing
- Reset:
  - Asserting `reset_n` low immediately forces state IDLE, cnt 0, and all input registers 0.
  - Outputs during reset: `heat_on` 0, `cool_on` 0, `rgb_out` 010, `state_out` 00.
  - Asserting reset mid-run drops the drive outputs asynchronously.
  - After reset release, the first tick may start a run; no lockout applies.
- Input-to-decision latency: inputs must be stable at the clk edge before the tick cycle. A change in the same cycle as `tick` is seen at the next tick.
- Decision-to-output latency: state and outputs change at the clk edge that ends the tick cycle.
- Run length: with `tick` every P clocks, HEAT/COOL last at least MIN_RUN ticks, and LOCKOUT lasts exactly MIN_OFF ticks. IDLE then evaluates on the following tick.
- `tick` held high on consecutive cycles is legal; each high cycle counts as one tick.

## Test plan
- Reset, then desired 72 / temp 70 / temp_set 1, with ticks → stays IDLE, `rgb_out` 010, no drive. Temp 69 then causes HEAT at the next tick, with `heat_on` 1 and `rgb_out` 100.
- HEAT entered with MIN_RUN=4, temp jumps to 75 one tick later → `heat_on` stays high through 4 ticks total, then LOCKOUT (110) for MIN_OFF=3 ticks, then IDLE (010).
- desired 60 / temp 63 → COOL (001). Temp falls to 60 after MIN_RUN → LOCKOUT. Setting temp 69 with desired 72 during lockout → no HEAT until IDLE, then HEAT on the next tick.
- `temp_set` dropped 1 tick into HEAT → run continues until cnt = 0, then LOCKOUT. Re-asserting `temp_set` during lockout gives no effect until IDLE.
- `reset_n` pulsed low mid-COOL, asynchronously between clk edges → `cool_on` falls without a clk edge and state reads 00. After release, a demand restarts COOL on the first tick with no lockout.
- Boundary: desired 127 / temp 0 / HYST 15 → need_heat with no overflow. desired 0 / temp 127 → need_cool. Ticks absent for 1000 cycles → state and cnt frozen.
